// File: rtl/core_pkg.sv
// core_pkg: shared constants, fetch FSM states and the offset helper
// used by the fetch stage and its next-PC adder.
package core_pkg;

  localparam logic [3:0] BR_CLASS = 4'hC;

  typedef enum logic {
    FETCH,
    VALID
  } fetch_state_e;

  function automatic logic [15:0] sext8(input logic [7:0] off);
    return {{8{off[7]}}, off};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory handshake plus the decode-side
// bundle (opCode, instr_valid, instr_pc, stall, BR).
interface fetch_unit_if #(
  parameter int PC_W = 16
);

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_rdata;
  logic [15:0]     opCode;
  logic            instr_valid;
  logic [PC_W-1:0] instr_pc;
  logic            stall;
  logic            BR;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output opCode,
    output instr_valid,
    output instr_pc,
    input  stall,
    input  BR
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  opCode,
    input  instr_valid,
    input  instr_pc,
    output stall,
    output BR
  );

endinterface

// File: rtl/fetch_nextpc.sv
// fetch_nextpc: combinational successor PC for the current opCode.
// Also used by debug/trace to report the branch destination.
module fetch_nextpc
  import core_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0] instr_pc,
  input  logic [15:0]     opCode,
  input  logic            BR,
  output logic [PC_W-1:0] next_pc
);

  logic            taken;
  logic [PC_W-1:0] off;
  logic            unused_cond;

  // Condition field is evaluated by the branch evaluator, not here
  assign unused_cond = ^opCode[11:8];

  // Sequential successor plus signed offset for a taken branch
  always_comb begin
    taken   = BR && (opCode[15:12] == BR_CLASS);
    off     = '0;
    if (taken)
      off = PC_W'($signed(sext8(opCode[7:0])));
    next_pc = instr_pc + PC_W'(1) + off;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, imem req/ack handshake and instruction register.
// Optional one-entry prefetch buffer: define FETCH_PREFETCH_EN.
module fetch_unit
  import core_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  fetch_state_e    state;
  logic            req;
  logic [PC_W-1:0] addr;
  logic [15:0]     op;
  logic            vld;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] next_pc;
  logic            consume;

  assign bus.imem_req    = req;
  assign bus.imem_addr   = addr;
  assign bus.opCode      = op;
  assign bus.instr_valid = vld;
  assign bus.instr_pc    = pc;

  assign consume = vld && !bus.stall;

  fetch_nextpc #(
    .PC_W(PC_W)
  ) u_nextpc (
    .instr_pc(pc),
    .opCode  (op),
    .BR      (bus.BR),
    .next_pc (next_pc)
  );

`ifdef FETCH_PREFETCH_EN

  logic            ack;
  logic            taken;
  logic            buf_vld;
  logic [15:0]     buf_op;
  logic [PC_W-1:0] buf_pc;
  logic            discard;
  logic [PC_W-1:0] redir;

  assign ack   = req && bus.imem_ack;
  assign taken = bus.BR && (op[15:12] == BR_CLASS);

  // Fetch FSM; VALID keeps fetching pc+1 into a one-entry buffer.
  // A stale prefetch still in flight at a redirect is drained first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      req     <= 1'b0;
      addr    <= RESET_PC;
      op      <= '0;
      vld     <= 1'b0;
      pc      <= '0;
      buf_vld <= 1'b0;
      buf_op  <= '0;
      buf_pc  <= '0;
      discard <= 1'b0;
      redir   <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (!req) begin
            req <= 1'b1;
          end else if (bus.imem_ack) begin
            if (discard) begin
              discard <= 1'b0;
              addr    <= redir;
            end else begin
              op    <= bus.imem_rdata;
              pc    <= addr;
              vld   <= 1'b1;
              addr  <= addr + PC_W'(1);
              state <= VALID;
            end
          end
        end
        VALID: begin
          if (consume) begin
            if (taken) begin
              vld     <= 1'b0;
              buf_vld <= 1'b0;
              state   <= FETCH;
              if (req && !bus.imem_ack) begin
                discard <= 1'b1;
                redir   <= next_pc;
              end else begin
                addr <= next_pc;
                req  <= 1'b1;
              end
            end else if (buf_vld) begin
              op      <= buf_op;
              pc      <= buf_pc;
              buf_vld <= 1'b0;
              addr    <= buf_pc + PC_W'(1);
              req     <= 1'b1;
            end else if (ack) begin
              op   <= bus.imem_rdata;
              pc   <= addr;
              addr <= addr + PC_W'(1);
            end else begin
              vld   <= 1'b0;
              state <= FETCH;
            end
          end else if (ack) begin
            buf_op  <= bus.imem_rdata;
            buf_pc  <= addr;
            buf_vld <= 1'b1;
            req     <= 1'b0;
          end
        end
      endcase
    end
  end

`else

  // Fetch FSM: one outstanding request, then hold until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      req   <= 1'b0;
      addr  <= RESET_PC;
      op    <= '0;
      vld   <= 1'b0;
      pc    <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (!req) begin
            req <= 1'b1;
          end else if (bus.imem_ack) begin
            op    <= bus.imem_rdata;
            pc    <= addr;
            vld   <= 1'b1;
            req   <= 1'b0;
            state <= VALID;
          end
        end
        VALID: begin
          if (consume) begin
            vld   <= 1'b0;
            addr  <= next_pc;
            req   <= 1'b1;
            state <= FETCH;
          end
        end
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors, corner sequences and a randomized
// run checked against an instruction-stream reference model.
module tb_fetch_unit;

  logic clk;
  logic rst;

  fetch_unit_if #(.PC_W(16)) bus ();

  fetch_unit #(
    .PC_W    (16),
    .RESET_PC(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [15:0] mem [0:65535];
  assign bus.imem_rdata = mem[bus.imem_addr];

  int pass_cnt = 0;
  int total_cnt = 0;
  int consumes = 0;
  int wait_cycles = 0;
  int wcnt = 0;
  bit rand_ack = 0;
  bit rand_stall = 0;
  bit rand_br = 0;
  bit stall_force = 1;
  bit br_force = 0;
  bit prev_req = 0;
  bit prev_ack = 0;
  logic [15:0] prev_addr = '0;
  logic [15:0] exp_pc = '0;
  logic ack;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] op;
    logic        br;
    logic [15:0] nxt;
  } vec_t;

  vec_t vecs [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Architectural successor: pc+1, plus signed 8-bit offset if taken
  function automatic logic [15:0] ref_next(input logic [15:0] p,
                                           input logic [15:0] o,
                                           input logic br);
    int off;
    int s;
    off = 0;
    if (o[15:12] == 4'hC && br) begin
      off = int'(o[7:0]);
      if (off >= 128) off = off - 256;
    end
    s = (int'(p) + 1 + off) & 32'hFFFF;
    return 16'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_valid(input logic [15:0] p, input int budget,
                            input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      if (bus.instr_valid && bus.instr_pc == p) break;
      tick();
    end
    check({name, "_reach"}, {31'b0, i < budget}, 32'd1);
  endtask

  // Memory/decoder stand-in plus stream model, evaluated mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      exp_pc = 16'h0000;
    end else if (prev_req && !prev_ack) begin
      check("req_hold", {31'b0, bus.imem_req}, 32'd1);
      check("addr_hold", {16'b0, bus.imem_addr}, {16'b0, prev_addr});
    end
    if (rst || !bus.imem_req) begin
      ack = 1'b0;
      wcnt = 0;
    end else if (rand_ack) begin
      ack = ($urandom_range(0, 2) == 0);
    end else if (wcnt >= wait_cycles) begin
      ack = 1'b1;
      wcnt = 0;
    end else begin
      ack = 1'b0;
      wcnt++;
    end
    bus.imem_ack = ack;
    bus.stall = rand_stall ? ($urandom_range(0, 3) == 0) : stall_force;
    if (rand_br) bus.BR = 1'($urandom_range(0, 1));
    else bus.BR = (bus.instr_pc == 16'h0000) ? 1'b1 : br_force;
    prev_req = bus.imem_req && !rst;
    prev_ack = ack;
    prev_addr = bus.imem_addr;
    if (!rst && bus.instr_valid && !bus.stall) begin
      consumes++;
      check("order_pc", {16'b0, bus.instr_pc}, {16'b0, exp_pc});
      check("order_op", {16'b0, bus.opCode}, {16'b0, mem[exp_pc]});
      exp_pc = ref_next(exp_pc, mem[exp_pc], bus.BR);
    end
  end

  initial begin
    vecs[0] = '{16'h0010, 16'hC4FE, 1'b1, 16'h000F};
    vecs[1] = '{16'h0010, 16'hC4FE, 1'b0, 16'h0011};
    vecs[2] = '{16'hFFFF, 16'hC002, 1'b1, 16'h0002};
    vecs[3] = '{16'hFFFF, 16'hC4FE, 1'b0, 16'h0000};
    vecs[4] = '{16'h0020, 16'h1234, 1'b1, 16'h0021};
    vecs[5] = '{16'h0010, 16'hC07F, 1'b1, 16'h0090};
    vecs[6] = '{16'h0010, 16'hC080, 1'b1, 16'hFF91};
    vecs[7] = '{16'h0040, 16'hB4FE, 1'b1, 16'h0041};

    rst = 1'b0;
    #1 rst = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1234;

    // reset values, zero-wait first fetch, stall hold
    repeat (2) tick();
    check("rst_req", {31'b0, bus.imem_req}, 32'd0);
    check("rst_addr", {16'b0, bus.imem_addr}, 32'h0);
    check("rst_op", {16'b0, bus.opCode}, 32'h0);
    check("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
    check("rst_pc", {16'b0, bus.instr_pc}, 32'h0);
    rst = 1'b0;
    tick();
    check("first_req", {31'b0, bus.imem_req}, 32'd1);
    check("first_addr", {16'b0, bus.imem_addr}, 32'h0);
    check("first_nvalid", {31'b0, bus.instr_valid}, 32'd0);
    tick();
    check("zw_valid", {31'b0, bus.instr_valid}, 32'd1);
    check("zw_op", {16'b0, bus.opCode}, 32'h1234);
    check("zw_pc", {16'b0, bus.instr_pc}, 32'h0);
`ifndef FETCH_PREFETCH_EN
    check("zw_req_drop", {31'b0, bus.imem_req}, 32'd0);
`endif
    for (int k = 0; k < 4; k++) begin
      tick();
      check("stall_op", {16'b0, bus.opCode}, 32'h1234);
      check("stall_pc", {16'b0, bus.instr_pc}, 32'h0);
      check("stall_valid", {31'b0, bus.instr_valid}, 32'd1);
`ifndef FETCH_PREFETCH_EN
      check("stall_noreq", {31'b0, bus.imem_req}, 32'd0);
`endif
    end

    // three wait cycles, then mid-handshake reset
    hold_reset();
    mem[0] = 16'hABCD;
    wait_cycles = 3;
    rst = 1'b0;
    tick();
    check("w3_req0", {31'b0, bus.imem_req}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("w3_req", {31'b0, bus.imem_req}, 32'd1);
      check("w3_addr", {16'b0, bus.imem_addr}, 32'h0);
      check("w3_nvalid", {31'b0, bus.instr_valid}, 32'd0);
    end
    tick();
    check("w3_valid", {31'b0, bus.instr_valid}, 32'd1);
    check("w3_op", {16'b0, bus.opCode}, 32'hABCD);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("w3_once_op", {16'b0, bus.opCode}, 32'hABCD);
      check("w3_once_pc", {16'b0, bus.instr_pc}, 32'h0);
    end
    stall_force = 1'b0;
    tick();
`ifndef FETCH_PREFETCH_EN
    check("mid_req", {31'b0, bus.imem_req}, 32'd1);
    check("mid_addr", {16'b0, bus.imem_addr}, 32'h1);
`endif
    rst = 1'b1;
    #1;
    check("arst_req", {31'b0, bus.imem_req}, 32'd0);
    check("arst_addr", {16'b0, bus.imem_addr}, 32'h0);
    check("arst_valid", {31'b0, bus.instr_valid}, 32'd0);
    check("arst_op", {16'b0, bus.opCode}, 32'h0);
    check("arst_pc", {16'b0, bus.instr_pc}, 32'h0);

    // table: jump from 0 to vector PC, execute vector word there
    wait_cycles = 0;
    for (int v = 0; v < 8; v++) begin
      int k;
      logic [15:0] jo;
      hold_reset();
      jo = vecs[v].pc - 16'h0001;
      mem[0] = {8'hC0, jo[7:0]};
      mem[vecs[v].pc] = vecs[v].op;
      br_force = vecs[v].br;
      rst = 1'b0;
      wait_valid(vecs[v].pc, 20, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_op", v), {16'b0, bus.opCode},
            {16'b0, vecs[v].op});
      tick();
`ifndef FETCH_PREFETCH_EN
      check($sformatf("vec%0d_req", v), {31'b0, bus.imem_req}, 32'd1);
      check($sformatf("vec%0d_addr", v), {16'b0, bus.imem_addr},
            {16'b0, vecs[v].nxt});
`endif
      for (k = 0; k < 10; k++) begin
        if (bus.instr_valid && bus.instr_pc != vecs[v].pc) break;
        tick();
      end
      check($sformatf("vec%0d_next", v), {16'b0, bus.instr_pc},
            {16'b0, vecs[v].nxt});
      rst = 1'b1;
      mem[vecs[v].pc] = 16'h0000;
    end

    // taken branch while the following fetch is still slow
    hold_reset();
    mem[0] = 16'hC005;
    mem[1] = 16'hDEAD;
    mem[6] = 16'h600D;
    br_force = 1'b0;
    wait_cycles = 2;
    rst = 1'b0;
    wait_valid(16'h0000, 20, "slowbr");
    tick();
    for (int k = 0; k < 20; k++) begin
      if (bus.instr_valid) break;
      tick();
    end
    check("slowbr_pc", {16'b0, bus.instr_pc}, 32'h6);
    check("slowbr_op", {16'b0, bus.opCode}, 32'h600D);

`ifdef FETCH_PREFETCH_EN
    // straight-line code: one instruction per cycle
    hold_reset();
    for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i);
    wait_cycles = 0;
    rst = 1'b0;
    wait_valid(16'h0000, 5, "pf");
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("pf_valid", {31'b0, bus.instr_valid}, 32'd1);
      check("pf_pc", {16'b0, bus.instr_pc}, k);
    end
`endif

    // randomized program, acks, stalls and branch outcomes
    hold_reset();
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 2) == 0) w[15:12] = 4'hC;
      mem[i] = w;
    end
    rand_ack = 1'b1;
    rand_stall = 1'b1;
    rand_br = 1'b1;
    consumes = 0;
    rst = 1'b0;
    repeat (2000) tick();
    check("rand_progress", {31'b0, consumes > 100}, 32'd1);
    rand_ack = 1'b0;
    wait_cycles = 0;
    consumes = 0;
    repeat (1000) tick();
    check("zw_progress", {31'b0, consumes > 200}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
